firefly_array: RTL and testbench
================================

FIREFLY_ARRAY -- requirements
Module: firefly_array

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning number of independent firefly channels (legal 1..32).
REQ-002 SHALL have parameter PULSE_LEN, default 15000, meaning f1 high time in clk cycles (legal 1..2^20-1).
REQ-003 SHALL have parameter DELAY, default 0, meaning clk cycles from detected queen edge to f1 rise (legal 0..2^20-1).
REQ-004 SHALL have port clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port en  input  1  global enable; low forces all channels idle.
REQ-007 SHALL have port mode  input  1  0 = ignore queen edges while a channel is busy, 1 = retrigger.
REQ-008 SHALL have port f0  input  N_CH  queen signal per channel.
REQ-009 SHALL have port f1  output  N_CH  sentinel pulse per channel, registered.
REQ-010 SHALL have port busy  output  N_CH  channel in DELAY or PULSE state, registered.
REQ-011 SHALL have port done  output  N_CH  one-cycle strobe on normal pulse completion, registered.

Function
REQ-012 SHALL run per channel a 3-state FSM: IDLE, WAIT (delay), PULSE; channels fully independent.
REQ-013 SHALL detect a queen edge as f0 sampled high with previous sample low; level alone never triggers.
REQ-014 SHALL, on an edge in IDLE with en=1: DELAY=0 -> PULSE next cycle; DELAY>0 -> WAIT next cycle.
REQ-015 SHALL stay in WAIT exactly DELAY cycles, then PULSE for exactly PULSE_LEN cycles, then IDLE.
REQ-016 SHALL drive f1=1 exactly while in PULSE; first f1 high cycle is edge cycle +1+DELAY (no-sync build).
REQ-017 SHALL drive busy=1 while in WAIT or PULSE.
REQ-018 SHALL pulse done for one cycle: the first cycle after the last PULSE cycle, only on normal completion.
REQ-019 SHALL, with mode=0, ignore edges in WAIT/PULSE, including an edge on the last PULSE cycle (lost, channel returns to IDLE).
REQ-020 SHALL, with mode=1, restart an edge in WAIT/PULSE from the start: counter reloaded, WAIT if DELAY>0 else PULSE; f1 stays high through a DELAY=0 retrigger; no done emitted for the aborted pulse.
REQ-021 SHALL size one down-counter per channel to $clog2(max(PULSE_LEN,DELAY)+1) bits; never wrap.
REQ-022 SHALL, on en=0, force every channel to IDLE next cycle with f1=busy=done=0; no done for aborted pulses.
REQ-023 SHALL keep updating the previous-sample register while en=0, so f0 already high when en rises does not trigger.
REQ-024 SHALL treat mode as sampled each cycle; a mode change affects only subsequent edges.

Reset
REQ-025 SHALL on rst_n=0 asynchronously set all FSMs IDLE, counters 0, previous-sample and sync registers 0, f1=busy=done=0.
REQ-026 SHALL, after reset release, treat f0 already high as a rising edge on the first enabled clock (previous sample is 0).
REQ-027 SHALL abort in-flight pulses on mid-operation reset with no done strobe.

Configuration
REQ-028 SHALL use macro FIREFLY_SYNC_EN: defined -> each f0 bit passes a 2-flop synchronizer before edge detection, adding exactly 2 cycles to every latency in REQ-016; undefined -> f0 sampled directly, no extra latency.

Verification
REQ-029 SHALL cover: N_CH=2, PULSE_LEN=750, DELAY=0, mode=0, f0[0] rises at cycle 10 -> f1[0] high cycles 11..760, done[0] at 761, f1[1] stays 0.
REQ-030 SHALL cover: PULSE_LEN=750, DELAY=100, f0 rises cycle 10 -> busy from 11, f1 high 111..860, done at 861.
REQ-031 SHALL cover: mode=0, second edge at cycle 400 of first pulse -> ignored, f1 falls at 761; mode=1 same stimulus -> f1 continuous to cycle 400+750, one done only.
REQ-032 SHALL cover: en dropped at cycle 300 mid-pulse -> f1=busy=0 from 301, no done; en raised with f0 held high -> no trigger.
REQ-033 SHALL cover: rst_n asserted at cycle 200 mid-pulse -> f1 low immediately (asynchronous), no done; after release with f0 high -> pulse starts.
REQ-034 SHALL cover: FIREFLY_SYNC_EN defined, REQ-029 stimulus -> f1[0] high cycles 13..762, done at 763.

Source files
------------

// File: rtl/firefly_array.sv
// firefly_array: N_CH independent queen-edge triggered pulse channels (IDLE -> WAIT -> PULSE).
// Optional build macro FIREFLY_SYNC_EN adds a 2-flop synchronizer on each f0 bit.

module firefly_ch #(
    parameter int PULSE_LEN = 15000,
    parameter int DELAY     = 0,
    parameter int CW        = 14
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic mode,
    input  logic f0,
    output logic f1,
    output logic busy,
    output logic done
);
    typedef enum logic [1:0] {IDLE, WAIT, PULSE} state_t;

    localparam bit            ZERO_DLY = (DELAY == 0);
    localparam logic [CW-1:0] PL_M1    = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] DL_M1    = CW'((DELAY == 0) ? 0 : DELAY - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          smp;
    logic          prev;
    logic          rise;

`ifdef FIREFLY_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[0], f0};
    end

    assign smp = sync[1];
`else
    assign smp = f0;
`endif

    assign rise = smp & ~prev;

    // Counter holds remaining cycles minus one; zero means this is the last cycle of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            prev  <= 1'b0;
            f1    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            prev <= smp;
            done <= 1'b0;
            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
                f1    <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state <= ZERO_DLY ? PULSE : WAIT;
                            cnt   <= ZERO_DLY ? PL_M1 : DL_M1;
                            f1    <= ZERO_DLY;
                            busy  <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (rise && mode) begin
                            state <= ZERO_DLY ? PULSE : WAIT;
                            cnt   <= ZERO_DLY ? PL_M1 : DL_M1;
                            f1    <= ZERO_DLY;
                        end else if (cnt == '0) begin
                            state <= PULSE;
                            cnt   <= PL_M1;
                            f1    <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    PULSE: begin
                        // A retrigger wins over completion, so an aborted pulse never strobes done.
                        if (rise && mode) begin
                            state <= ZERO_DLY ? PULSE : WAIT;
                            cnt   <= ZERO_DLY ? PL_M1 : DL_M1;
                            f1    <= ZERO_DLY;
                        end else if (cnt == '0) begin
                            state <= IDLE;
                            f1    <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        f1    <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

module firefly_array #(
    parameter int N_CH      = 4,
    parameter int PULSE_LEN = 15000,
    parameter int DELAY     = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            mode,
    input  logic [N_CH-1:0] f0,
    output logic [N_CH-1:0] f1,
    output logic [N_CH-1:0] busy,
    output logic [N_CH-1:0] done
);
    localparam int MAXV = (PULSE_LEN > DELAY) ? PULSE_LEN : DELAY;
    localparam int CW   = $clog2(MAXV + 1);

    firefly_ch #(
        .PULSE_LEN (PULSE_LEN),
        .DELAY     (DELAY),
        .CW        (CW)
    ) u_ch [N_CH-1:0] (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .f0    (f0),
        .f1    (f1),
        .busy  (busy),
        .done  (done)
    );
endmodule

// File: tb/tb_firefly_array.sv
// Bench for firefly_array: three configurations checked every cycle against a time-window model.
module tb_firefly_array;
`ifdef FIREFLY_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, en, mode;
    logic [3:0] f0;
    logic [1:0] f1a, bsa, dna, f1b, bsb, dnb;
    logic [3:0] f1c, bsc, dnc;

    always #10 clk = ~clk;

    firefly_array #(.N_CH(2), .PULSE_LEN(750), .DELAY(0)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .f0(f0[1:0]),
        .f1(f1a), .busy(bsa), .done(dna));
    firefly_array #(.N_CH(2), .PULSE_LEN(750), .DELAY(100)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .f0(f0[1:0]),
        .f1(f1b), .busy(bsb), .done(dnb));
    firefly_array #(.N_CH(4), .PULSE_LEN(5), .DELAY(3)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .f0(f0),
        .f1(f1c), .busy(bsc), .done(dnc));

    // Model: a channel is a trigger time t0; outputs follow from elapsed edges since t0.
    int dly[3] = '{0, 100, 3};
    int pl[3]  = '{750, 750, 5};
    int nch[3] = '{2, 2, 4};
    bit act[3][4];
    int t0[3][4];
    bit prv[3][4];
    bit h1[4], h2[4];
    int k;
    int npass, ntot;
    int cf1a, cda, cq, cf1b, cdb;

    task automatic model_reset();
        for (int i = 0; i < 3; i++)
            for (int c = 0; c < 4; c++) begin
                act[i][c] = 1'b0;
                prv[i][c] = 1'b0;
            end
        for (int c = 0; c < 4; c++) begin
            h1[c] = 1'b0;
            h2[c] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit s, r, was_busy;
        if (!rst_n) return;
        k++;
        for (int i = 0; i < 3; i++)
            for (int c = 0; c < nch[i]; c++) begin
                s = SYNC ? h2[c] : f0[c];
                r = s && !prv[i][c];
                prv[i][c] = s;
                if (!en) act[i][c] = 1'b0;
                else if (r) begin
                    was_busy = act[i][c] && (k - 1 - t0[i][c]) < dly[i] + pl[i];
                    if (!was_busy || mode) begin
                        act[i][c] = 1'b1;
                        t0[i][c]  = k;
                    end
                end
            end
        for (int c = 0; c < 4; c++) begin
            h2[c] = h1[c];
            h1[c] = f0[c];
        end
    endtask

    function automatic logic [3:0] expv(int i, int which);
        logic [3:0] v = '0;
        int d;
        for (int c = 0; c < nch[i]; c++) begin
            d = k - t0[i][c];
            if (act[i][c]) begin
                case (which)
                    0: v[c] = (d >= dly[i]) && (d < dly[i] + pl[i]);
                    1: v[c] = (d >= 0) && (d < dly[i] + pl[i]);
                    default: v[c] = (d == dly[i] + pl[i]);
                endcase
            end
        end
        return v;
    endfunction

    function automatic logic [3:0] obsv(int i, int which);
        case (i)
            0: return (which == 0) ? {2'b0, f1a} : (which == 1) ? {2'b0, bsa} : {2'b0, dna};
            1: return (which == 0) ? {2'b0, f1b} : (which == 1) ? {2'b0, bsb} : {2'b0, dnb};
            default: return (which == 0) ? f1c : (which == 1) ? bsc : dnc;
        endcase
    endfunction

    task automatic check();
        string nm[3] = '{"f1", "busy", "done"};
        logic [3:0] o, e;
        for (int i = 0; i < 3; i++)
            for (int w = 0; w < 3; w++) begin
                o = obsv(i, w);
                e = expv(i, w);
                ntot++;
                assert (o === e) npass++;
                else $error("FAIL %s inst%0d edge%0d got %b want %b", nm[w], i, k, o, e);
            end
    endtask

    task automatic check_eq(string tag, int got, int want);
        ntot++;
        assert (got === want) npass++;
        else $error("FAIL %s got %0d want %0d", tag, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check();
        cf1a += int'(f1a[0]);
        cda  += int'(dna[0]);
        cq   += int'(f1a[1]);
        cf1b += int'(f1b[0]);
        cdb  += int'(dnb[0]);
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic clr();
        cf1a = 0; cda = 0; cq = 0; cf1b = 0; cdb = 0;
    endtask

    initial begin
        npass = 0; ntot = 0; k = 0;
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; f0 = '0;
        clr();
        model_reset();
        #5;
        check();
        run(2);
        rst_n = 1'b1;

        // Single trigger, DELAY=0 and DELAY=100
        en = 1'b1;
        run(9);
        clr();
        f0 = 4'b0001;
        run(880);
        check_eq("a0 pulse len", cf1a, 750);
        check_eq("a0 done cnt", cda, 1);
        check_eq("a1 stays low", cq, 0);
        check_eq("b0 pulse len", cf1b, 750);
        check_eq("b0 done cnt", cdb, 1);

        // Second edge mid-pulse, mode 0 then mode 1
        f0 = '0; run(5); clr();
        f0 = 4'b0001; run(389);
        f0 = '0; run(1);
        f0 = 4'b0001; run(900);
        check_eq("mode0 len", cf1a, 750);
        check_eq("mode0 done", cda, 1);
        mode = 1'b1;
        f0 = '0; run(5); clr();
        f0 = 4'b0001; run(389);
        f0 = '0; run(1);
        f0 = 4'b0001; run(900);
        check_eq("mode1 len", cf1a, 1140);
        check_eq("mode1 done", cda, 1);

        // Enable drop mid-pulse, then re-enable with f0 held high
        mode = 1'b0;
        f0 = '0; run(5); clr();
        f0 = 4'b0001; run(300);
        en = 1'b0; run(5);
        check_eq("en abort done", cda, 0);
        check_eq("en abort f1 low", int'(f1a[0]), 0);
        clr();
        en = 1'b1; run(900);
        check_eq("en rise no trig", cf1a, 0);
        check_eq("en rise no done", cda, 0);

        // Asynchronous reset mid-pulse, release with f0 high
        f0 = '0; run(5);
        f0 = 4'b0001; run(200);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check();
        check_eq("async rst f1", int'(f1a[0]), 0);
        run(2);
        rst_n = 1'b1;
        clr();
        run(900);
        check_eq("post rst len", cf1a, 750);
        check_eq("post rst done", cda, 1);

        // Random traffic, mostly exercising the short configuration
        for (int n = 0; n < 3000; n++) begin
            en   = ($urandom_range(0, 19) != 0);
            mode = ($urandom_range(0, 63) == 0) ? ~mode : mode;
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 7) == 0) f0[c] = ~f0[c];
            tick();
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
